// File: rtl/gray_sync_pkg.sv
// Shared helpers and limits for the read-side Gray pointer synchronizer.
package gray_sync_pkg;

  localparam int unsigned MIN_SYNC_STAGES = 2;
  localparam int unsigned MAX_SYNC_STAGES = 4;
  localparam int unsigned MIN_NCH         = 1;
  localparam int unsigned MAX_NCH         = 8;

  // Helper word width; narrower pointers are zero-extended, which leaves the
  // prefix-XOR result of the low bits unchanged.
  localparam int unsigned FUNC_W = 32;

  // Gray to binary: b[MSB]=g[MSB], b[i]=b[i+1]^g[i].
  function automatic logic [FUNC_W-1:0] gray2bin(input logic [FUNC_W-1:0] g);
    logic [FUNC_W-1:0] b;
    b[FUNC_W-1] = g[FUNC_W-1];
    for (int i = FUNC_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  // True when more than one bit differs between two Gray samples.
  function automatic logic multi_bit_change(input logic [FUNC_W-1:0] a,
                                            input logic [FUNC_W-1:0] b);
    return ($countones(a ^ b) > 1);
  endfunction

endpackage

// File: rtl/gray_ptr_sync_rd_if.sv
// Write-pointer crossing bundle between the write side and the read controller.
interface gray_ptr_sync_rd_if #(
  parameter int unsigned ADRRSIZE = 3,
  parameter int unsigned NCH      = 1
);
  localparam int unsigned PW = ADRRSIZE + 1;

  logic [NCH*PW-1:0] wptr_gray;
  logic              err_clr;
  logic [NCH*PW-1:0] rq_wptr_gray;
  logic [NCH*PW-1:0] rq_wptr_bin;
  logic [NCH-1:0]    rq_wptr_upd;
  logic [NCH-1:0]    gray_err;

  modport master (
    output wptr_gray, err_clr,
    input  rq_wptr_gray, rq_wptr_bin, rq_wptr_upd, gray_err
  );

  modport slave (
    input  wptr_gray, err_clr,
    output rq_wptr_gray, rq_wptr_bin, rq_wptr_upd, gray_err
  );
endinterface

// File: rtl/gray_ptr_sync_rd_sync_chain.sv
// One channel's synchronizer flop chain, synchronous active-high reset.
module sync_chain #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned STAGES = 2
) (
  input  logic             rclk,
  input  logic             rrst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_q [STAGES];

  // Shift the sample down the chain; reset discards everything in flight.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      for (int i = 0; i < int'(STAGES); i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= d;
      for (int i = 1; i < int'(STAGES); i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign q = stage_q[STAGES-1];

endmodule

// File: rtl/gray_ptr_sync_rd.sv
// Read-domain synchronizer for NCH Gray write pointers with registered binary
// copy and change pulse. Optional Gray-legality check: define GRAY_CHECK_EN.
module gray_ptr_sync_rd
  import gray_sync_pkg::*;
#(
  parameter int unsigned ADRRSIZE    = 3,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned NCH         = 1
) (
  input  logic               rclk,
  input  logic               rrst,
  gray_ptr_sync_rd_if.slave  bus
);

  localparam int unsigned PW = ADRRSIZE + 1;
  localparam int unsigned VW = NCH * PW;

  // Reject unsupported configurations at elaboration.
  if (SYNC_STAGES < MIN_SYNC_STAGES || SYNC_STAGES > MAX_SYNC_STAGES) begin : g_bad_stages
    $error("gray_ptr_sync_rd: SYNC_STAGES=%0d out of range", SYNC_STAGES);
  end
  if (NCH < MIN_NCH || NCH > MAX_NCH) begin : g_bad_nch
    $error("gray_ptr_sync_rd: NCH=%0d out of range", NCH);
  end

  logic [VW-1:0]  sync_q;
  logic [VW-1:0]  bin_nxt;
  logic [NCH-1:0] chg;
  logic [VW-1:0]  bin_q;
  logic [NCH-1:0] upd_q;

  // One independent chain per channel.
  for (genvar c = 0; c < int'(NCH); c++) begin : g_chan
    sync_chain #(.WIDTH(PW), .STAGES(SYNC_STAGES)) u_chain (
      .rclk (rclk),
      .rrst (rrst),
      .d    (bus.wptr_gray[c*PW +: PW]),
      .q    (sync_q[c*PW +: PW])
    );
  end

  assign bus.rq_wptr_gray = sync_q;

  // Binary conversion of the last stage and per-channel change detect.
  always_comb begin
    bin_nxt = '0;
    chg     = '0;
    for (int c = 0; c < int'(NCH); c++) begin
      bin_nxt[c*PW +: PW] = PW'(gray2bin(FUNC_W'(sync_q[c*PW +: PW])));
      chg[c]              = (bin_nxt[c*PW +: PW] != bin_q[c*PW +: PW]);
    end
  end

  // Register the binary copy and the change pulse.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      bin_q <= '0;
      upd_q <= '0;
    end else begin
      bin_q <= bin_nxt;
      upd_q <= chg;
    end
  end

  assign bus.rq_wptr_bin = bin_q;
  assign bus.rq_wptr_upd = upd_q;

`ifdef GRAY_CHECK_EN
  // Warm-up covers the chain refill plus the first compare against the reset value.
  localparam int unsigned WARM = SYNC_STAGES + 1;
  localparam int unsigned CW   = $clog2(WARM + 1);

  logic [CW-1:0]  warm_q;
  logic [VW-1:0]  prev_q;
  logic [NCH-1:0] err_q;
  logic [NCH-1:0] bad;
  logic           chk_en;

  assign chk_en = (warm_q == CW'(WARM));

  // Flag any channel whose synchronized Gray value moved by more than one bit.
  always_comb begin
    bad = '0;
    for (int c = 0; c < int'(NCH); c++) begin
      bad[c] = multi_bit_change(FUNC_W'(sync_q[c*PW +: PW]), FUNC_W'(prev_q[c*PW +: PW]));
    end
  end

  // Saturating warm-up counter, previous-sample register and sticky error bits.
  always_ff @(posedge rclk) begin
    if (rrst) begin
      warm_q <= '0;
      prev_q <= '0;
      err_q  <= '0;
    end else begin
      if (!chk_en) begin
        warm_q <= warm_q + CW'(1);
      end
      prev_q <= sync_q;
      err_q  <= (err_q & ~{NCH{bus.err_clr}}) | (bad & {NCH{chk_en}});
    end
  end

  assign bus.gray_err = err_q;
`else
  assign bus.gray_err = '0;
`endif

endmodule

// File: tb/tb_gray_ptr_sync_rd.sv
// Directed bench for gray_ptr_sync_rd: ADRRSIZE=3, SYNC_STAGES=3, NCH=4.
module tb_gray_ptr_sync_rd;

  localparam int unsigned ADRRSIZE    = 3;
  localparam int unsigned SYNC_STAGES = 3;
  localparam int unsigned NCH         = 4;

`ifdef GRAY_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  typedef struct {
    logic        rst;
    logic [15:0] wptr;
    logic [15:0] gray;
    logic [15:0] bin;
    logic [3:0]  upd;
  } vec_t;

  logic rclk = 1'b0;
  logic rrst;
  int   checks   = 0;
  int   failures = 0;
  vec_t vq[$];

  gray_ptr_sync_rd_if #(.ADRRSIZE(ADRRSIZE), .NCH(NCH)) ifc ();

  gray_ptr_sync_rd #(
    .ADRRSIZE    (ADRRSIZE),
    .SYNC_STAGES (SYNC_STAGES),
    .NCH         (NCH)
  ) dut (
    .rclk (rclk),
    .rrst (rrst),
    .bus  (ifc)
  );

  always #5 rclk = ~rclk;

  task automatic tick();
    @(posedge rclk);
    #1;
  endtask

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic void av(input logic rst, input logic [15:0] wptr, input logic [15:0] gray,
                             input logic [15:0] bin, input logic [3:0] upd);
    vq.push_back('{rst: rst, wptr: wptr, gray: gray, bin: bin, upd: upd});
  endfunction

  initial begin
    logic [3:0]  g;
    logic [3:0]  exp_err;

    rrst            = 1'b1;
    ifc.wptr_gray   = 16'hFFFF;
    ifc.err_clr     = 1'b0;

    // Reset with all-ones input, then release and watch the chain refill.
    av(1, 16'hFFFF, 16'h0000, 16'h0000, 4'h0);
    av(1, 16'hFFFF, 16'h0000, 16'h0000, 4'h0);
    av(1, 16'hFFFF, 16'h0000, 16'h0000, 4'h0);
    av(0, 16'hFFFF, 16'h0000, 16'h0000, 4'h0);
    av(0, 16'hFFFF, 16'h0000, 16'h0000, 4'h0);
    av(0, 16'hFFFF, 16'hFFFF, 16'h0000, 4'h0);
    av(0, 16'hFFFF, 16'hFFFF, 16'hAAAA, 4'hF);
    av(0, 16'hFFFF, 16'hFFFF, 16'hAAAA, 4'h0);
    // Reset from non-zero outputs, then the 0000->0001 latency step on ch0.
    av(1, 16'h0000, 16'h0000, 16'h0000, 4'h0);
    av(0, 16'h0000, 16'h0000, 16'h0000, 4'h0);
    av(0, 16'h0000, 16'h0000, 16'h0000, 4'h0);
    av(0, 16'h0000, 16'h0000, 16'h0000, 4'h0);
    av(0, 16'h0000, 16'h0000, 16'h0000, 4'h0);
    av(0, 16'h0001, 16'h0000, 16'h0000, 4'h0);
    av(0, 16'h0001, 16'h0000, 16'h0000, 4'h0);
    av(0, 16'h0001, 16'h0001, 16'h0000, 4'h0);
    av(0, 16'h0001, 16'h0001, 16'h0001, 4'h1);
    av(0, 16'h0001, 16'h0001, 16'h0001, 4'h0);
    // Channel 2 alone moves; other channels hold.
    av(0, 16'h0101, 16'h0001, 16'h0001, 4'h0);
    av(0, 16'h0101, 16'h0001, 16'h0001, 4'h0);
    av(0, 16'h0101, 16'h0101, 16'h0001, 4'h0);
    av(0, 16'h0101, 16'h0101, 16'h0101, 4'h4);
    av(0, 16'h0101, 16'h0101, 16'h0101, 4'h0);
    av(0, 16'h0301, 16'h0101, 16'h0101, 4'h0);
    av(0, 16'h0301, 16'h0101, 16'h0101, 4'h0);
    av(0, 16'h0301, 16'h0301, 16'h0101, 4'h0);
    av(0, 16'h0301, 16'h0301, 16'h0201, 4'h4);
    av(0, 16'h0301, 16'h0301, 16'h0201, 4'h0);

    for (int i = 0; i < vq.size(); i++) begin
      rrst          = vq[i].rst;
      ifc.wptr_gray = vq[i].wptr;
      tick();
      chk($sformatf("vec%0d_gray", i), ifc.rq_wptr_gray, vq[i].gray);
      chk($sformatf("vec%0d_bin", i), ifc.rq_wptr_bin, vq[i].bin);
      chk($sformatf("vec%0d_upd", i), 16'(ifc.rq_wptr_upd), 16'(vq[i].upd));
      chk($sformatf("vec%0d_err", i), 16'(ifc.gray_err), 16'h0000);
    end

    // Mid-run reset with a sample in flight, then a multi-bit jump during warm-up.
    ifc.wptr_gray = 16'h0303;
    tick();
    tick();
    rrst = 1'b1;
    tick();
    chk("midrst_gray", ifc.rq_wptr_gray, 16'h0000);
    chk("midrst_bin", ifc.rq_wptr_bin, 16'h0000);
    chk("midrst_upd", 16'(ifc.rq_wptr_upd), 16'h0000);
    chk("midrst_err", 16'(ifc.gray_err), 16'h0000);
    rrst          = 1'b0;
    ifc.wptr_gray = 16'h0F0F;
    for (int e = 1; e <= 5; e++) begin
      tick();
      chk($sformatf("post_e%0d_gray", e), ifc.rq_wptr_gray, (e >= 3) ? 16'h0F0F : 16'h0000);
      chk($sformatf("post_e%0d_bin", e), ifc.rq_wptr_bin, (e >= 4) ? 16'h0A0A : 16'h0000);
      chk($sformatf("post_e%0d_upd", e), 16'(ifc.rq_wptr_upd), (e == 4) ? 16'h0005 : 16'h0000);
      chk($sformatf("post_e%0d_err", e), 16'(ifc.gray_err), 16'h0000);
    end

    // Walk ch1 through the Gray sequence including the 1000->0000 wrap.
    for (int i = 1; i <= 16; i++) begin
      int unsigned v;
      v = i % 16;
      g = 4'(v ^ (v >> 1));
      ifc.wptr_gray = 16'h0F0F | (16'(g) << 4);
      tick();
      tick();
      tick();
      chk($sformatf("walk%0d_pre_upd", i), 16'(ifc.rq_wptr_upd), 16'h0000);
      tick();
      chk($sformatf("walk%0d_bin", i), ifc.rq_wptr_bin, 16'h0A0A | 16'(v << 4));
      chk($sformatf("walk%0d_upd", i), 16'(ifc.rq_wptr_upd), 16'h0002);
      tick();
      chk($sformatf("walk%0d_upd_off", i), 16'(ifc.rq_wptr_upd), 16'h0000);
    end
    chk("walk_err", 16'(ifc.gray_err), 16'h0000);

    // Illegal jump on ch1 (0000->0011), sticky flag, then clear.
    exp_err = CHK ? 4'b0010 : 4'b0000;
    ifc.wptr_gray = 16'h0F3F;
    tick();
    tick();
    tick();
    chk("bad1_before", 16'(ifc.gray_err), 16'h0000);
    tick();
    chk("bad1_set", 16'(ifc.gray_err), 16'(exp_err));
    tick();
    tick();
    chk("bad1_sticky", 16'(ifc.gray_err), 16'(exp_err));
    ifc.err_clr = 1'b1;
    tick();
    ifc.err_clr = 1'b0;
    chk("clr_no_new", 16'(ifc.gray_err), 16'h0000);

    // Second illegal jump (0011->0000) lands on the same edge as err_clr.
    ifc.wptr_gray = 16'h0F0F;
    tick();
    tick();
    tick();
    chk("bad2_before", 16'(ifc.gray_err), 16'h0000);
    ifc.err_clr = 1'b1;
    tick();
    ifc.err_clr = 1'b0;
    chk("clr_vs_new", 16'(ifc.gray_err), 16'(exp_err));
    tick();
    chk("clr_vs_new_hold", 16'(ifc.gray_err), 16'(exp_err));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
